// File: rtl/fwd_fft_pkg.sv
// Shared widths, queue entry type and twiddle address helper for the
// forward FFT twiddle feeder.
package fwd_fft_pkg;

    localparam int SAMPLE_W = 24;
    localparam int TWID_W   = 16;
    localparam int PROD_W   = 32;
    localparam int MUL_LAT  = 4;

    typedef struct packed {
        logic              last;
        logic [PROD_W-1:0] prod;
    } q_entry_t;

    // Twiddle index for sample n of a stage-s pass: (n mod 2^s) << (log2_n-1-s),
    // with s clamped to log2_n-1. The caller truncates to its address width.
    function automatic logic [31:0] tw_addr_f(input logic [31:0] n,
                                              input logic [31:0] s,
                                              input int          log2_n);
        logic [31:0] s_c;
        logic [31:0] mask;
        s_c  = (s >= 32'(log2_n)) ? 32'(log2_n - 1) : s;
        mask = (32'd1 << s_c) - 32'd1;
        return (n & mask) << (32'(log2_n - 1) - s_c);
    endfunction

endpackage

// File: rtl/fwd_fft_out_queue2.sv
// Two-entry output FIFO for {last, product} with registered head outputs
// and an occupancy count used by the feeder to throttle its pipeline.
module fwd_fft_out_queue2
    import fwd_fft_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  q_entry_t          push_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [PROD_W-1:0] out_data,
    output logic              out_last,
    output logic [1:0]        count
);

    q_entry_t   head_q, head_d;
    q_entry_t   tail_q, tail_d;
    logic [1:0] count_q, count_d;
    logic       pop;
    logic       do_push;

    assign pop     = (count_q != 2'd0) && out_ready;
    assign do_push = push && ((count_q != 2'd2) || pop);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case ({do_push, pop})
            2'b10: begin
                if (count_q == 2'd0) head_d = push_data;
                else                 tail_d = push_data;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    head_d = push_data;
                end else begin
                    head_d = tail_q;
                    tail_d = push_data;
                end
            end
            default: ;
        endcase
    end

    // NOTE: the two storage entries are reset too, so out_data/out_last read 0 out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign out_valid = (count_q != 2'd0);
    assign out_data  = head_q.prod;
    assign out_last  = head_q.last;
    assign count     = count_q;

endmodule

// File: rtl/fwd_fft_twiddle_feeder.sv
// Pairs each framed sample with its per-stage twiddle, drives the external
// 4-cycle multiplier and queues the products with valid/ready back-pressure.
module fwd_fft_twiddle_feeder
    import fwd_fft_pkg::*;
#(
    parameter int LOG2_N  = 10,
    parameter int MUL_LAT = fwd_fft_pkg::MUL_LAT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [$clog2(LOG2_N)-1:0]  cfg_stage,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [SAMPLE_W-1:0]        in_data,
    input  logic                       in_last,
    output logic                       tw_en,
    output logic [LOG2_N-2:0]          tw_addr,
    input  logic [TWID_W-1:0]          tw_data,
    output logic                       mul_ce,
    output logic [SAMPLE_W-1:0]        mul_din0,
    output logic [TWID_W-1:0]          mul_din1,
    input  logic [PROD_W-1:0]          mul_dout,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PROD_W-1:0]          out_data,
    output logic                       out_last,
    output logic                       frame_err
);

    localparam int               AW     = LOG2_N - 1;
    localparam int               SW     = $clog2(LOG2_N);
    localparam logic [LOG2_N-1:0] N_LAST = '1;

    logic                run_q, run_d;
    logic [LOG2_N-1:0]   n_q, n_d;
    logic [SW-1:0]       stage_q, stage_d;
    logic                err_q, err_d;
    logic [SAMPLE_W-1:0] din0_q, din0_d;
    logic                tw_rd_q, tw_rd_d;
    logic [TWID_W-1:0]   din1_hold_q, din1_hold_d;
    logic [MUL_LAT:0]    tag_v_q, tag_v_d;
    logic [MUL_LAT:0]    tag_l_q, tag_l_d;

    logic [1:0]    q_count;
    logic          en;
    logic          accept;
    logic [SW-1:0] s_cur;
    q_entry_t      q_push_data;

    // Stall is decided from queue occupancy alone, never from out_ready.
    assign en     = run_q && (q_count != 2'd2);
    assign accept = en && in_valid;

    assign in_ready = en;
    assign tw_en    = en;
    assign mul_ce   = en;

    assign s_cur   = (n_q == '0) ? cfg_stage : stage_q;
    assign tw_addr = AW'(tw_addr_f(32'(n_q), 32'(s_cur), LOG2_N));

    always_comb begin
        run_d       = 1'b1;
        n_d         = n_q;
        stage_d     = stage_q;
        err_d       = err_q;
        if (accept) begin
            if (n_q == '0) stage_d = cfg_stage;
            if (in_last != (n_q == N_LAST)) err_d = 1'b1;
            n_d = (in_last || (n_q == N_LAST)) ? '0 : n_q + 1'b1;
        end
        din0_d      = en ? in_data : din0_q;
        tw_rd_d     = en;
        // ROM data is only fresh the cycle after a read; keep a copy for stalls.
        din1_hold_d = tw_rd_q ? tw_data : din1_hold_q;
        tag_v_d     = en ? {tag_v_q[MUL_LAT-1:0], accept} : tag_v_q;
        tag_l_d     = en ? {tag_l_q[MUL_LAT-1:0], accept & in_last} : tag_l_q;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_q       <= 1'b0;
            n_q         <= '0;
            stage_q     <= '0;
            err_q       <= 1'b0;
            din0_q      <= '0;
            tw_rd_q     <= 1'b0;
            din1_hold_q <= '0;
            tag_v_q     <= '0;
            tag_l_q     <= '0;
        end else begin
            run_q       <= run_d;
            n_q         <= n_d;
            stage_q     <= stage_d;
            err_q       <= err_d;
            din0_q      <= din0_d;
            tw_rd_q     <= tw_rd_d;
            din1_hold_q <= din1_hold_d;
            tag_v_q     <= tag_v_d;
            tag_l_q     <= tag_l_d;
        end
    end

    assign mul_din0  = din0_q;
    assign mul_din1  = tw_rd_q ? tw_data : din1_hold_q;
    assign frame_err = err_q;

    assign q_push_data = '{last: tag_l_q[MUL_LAT], prod: mul_dout};

    fwd_fft_out_queue2 u_out_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (en && tag_v_q[MUL_LAT]),
        .push_data (q_push_data),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .count     (q_count)
    );

endmodule

// File: doc/fwd_fft_twiddle_feeder.md
Name: fwd_fft_twiddle_feeder

Overview:
- Upstream operand stage for the 24x16 unsigned, 4-cycle DSP multiplier in the forward FFT datapath.
- Accepts a framed stream of 24-bit sample magnitudes and generates the per-stage twiddle ROM address for each sample.
- Pairs each sample with the 16-bit twiddle word and drives the multiplier's din0, din1 and ce.
- Tracks valid/last through the multiplier latency and buffers the 32-bit products in a 2-entry output queue with valid/ready.

Parameters:
- LOG2_N, 10, log2 of FFT frame length N; the twiddle address is LOG2_N-1 bits wide.
- MUL_LAT, 4, multiplier pipeline latency in ce-qualified cycles.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cfg_stage  in  $clog2(LOG2_N)  FFT stage s, sampled on the first accepted beat of each frame.
- in_valid  in  1  sample valid.
- in_ready  out  1  sample accepted when in_valid and in_ready are both high.
- in_data  in  24  unsigned sample magnitude.
- in_last  in  1  marks the last beat of the frame.
- tw_en  out  1  twiddle ROM read enable.
- tw_addr  out  LOG2_N-1  twiddle ROM address.
- tw_data  in  16  ROM data; valid one cycle after an address is presented with tw_en high.
- mul_ce  out  1  multiplier clock enable.
- mul_din0  out  24  multiplier operand a (sample).
- mul_din1  out  16  multiplier operand b (twiddle).
- mul_dout  in  32  multiplier product.
- out_valid  out  1  product valid.
- out_ready  in  1  downstream accept.
- out_data  out  32  product.
- out_last  out  1  frame last, aligned with out_data.
- frame_err  out  1  sticky in_last/count mismatch flag.

Behaviour:
- Pipeline enable: en = (queue count < 2). en is registered-state based and never depends combinationally on out_ready.
- Port mapping: in_ready = en, tw_en = en, mul_ce = en.
- Accept at cycle t, no stalls:
  - tw_addr is presented combinationally at t.
  - The sample, last bit and valid tag are registered at t.
  - Operands are held on mul_din0/mul_din1 from t+1, when tw_data arrives.
  - The product enters the queue at the edge ending cycle t+1+MUL_LAT.
  - out_valid rises at t+6 (1 ROM + 4 multiplier + 1 queue).
- Throughput: when out_ready is held high, one product per cycle with no bubbles.
- Stall: when en is low, every pipeline register holds, including the operand hold registers and the valid/last tag shift register (MUL_LAT+1 entries). The multiplier is frozen through mul_ce. No beat is lost or duplicated.
- Valid tag: a tag valid bit is 1 only for accepted beats. A bubble (in_valid low while en is high) shifts a 0 through the tag register.
- Sample counter n (LOG2_N bits):
  - Increments on each accept.
  - Returns to 0 after accepting a beat with in_last high, or when it wraps from N-1.
  - frame_err sets if in_last is high with n != N-1, or if in_last is low with n == N-1. frame_err clears only on reset.
- Stage latch: cfg_stage is captured into stage_r when a beat is accepted with n == 0. The first beat of a frame uses cfg_stage directly.
- Address: tw_addr = (n mod 2^s) << (LOG2_N-1-s).
  - s = 0 gives address 0.
  - Values of s >= LOG2_N are clamped to LOG2_N-1.
  - tw_addr is driven whenever en is high; when in_valid is low it is don't-care but still deterministic.
- Queue: 2-entry FIFO holding {last, product}.
  - Push and pop in the same cycle leave count unchanged.
  - out_data and out_last come from the head entry and are registered.
- Reset values:
  - in_ready = 0 while reset is asserted, 1 after release.
  - out_valid = 0, out_data = 0, out_last = 0.
  - mul_din0 = 0, mul_din1 = 0.
  - frame_err = 0, n = 0, stage_r = 0.
  - Tag register and queue are cleared.
- Reset mid-frame: all in-flight beats are discarded and the next accepted beat starts a new frame.

Decomposition:
- Shared package fwd_fft_pkg holds:
  - SAMPLE_W = 24, TWID_W = 16, PROD_W = 32, MUL_LAT = 4.
  - A typedef for the {last, product} queue entry.
  - An address function tw_addr_f(n, s, LOG2_N).
- One natural sub-module: fwd_fft_out_queue2, the 2-entry FIFO with count output.
- The multiplier and the twiddle ROM are external to this block.

Test Plan:
- Single beat, s=0, in_data=0x000100, ROM model returns 0x8000, reference multiplier model attached, out_ready=1 -> tw_addr=0; out_data=0x00800000 with out_last=0 exactly 6 cycles after the accept.
- LOG2_N=3, s=2, full frame of 8 beats back-to-back -> tw_addr sequence 0,1,2,3,0,1,2,3; 8 consecutive out_valid cycles; out_last on the 8th beat only; frame_err=0.
- Same frame with out_ready=0 from cycle 3 to cycle 12 -> in_ready falls once the queue holds 2 entries; after release all 8 products arrive in order with none lost or duplicated.
- in_last asserted on beat 5 of an 8-beat frame -> frame_err=1 from the next cycle; n restarts at 0; the following frame's addresses are correct.
- Assert reset with 3 beats in flight -> out_valid=0 during and after reset; none of the 3 products ever appear; the next frame starts at tw_addr=0.
- Alternate in_valid 1/0 with out_ready toggling randomly, checked against a scoreboard -> out_data equals in_data*tw_data modulo 2^32 in order, and the last bits match.
